// File: rtl/usb_line_tx.sv
// Full-speed USB line transmitter: serialises packet bytes into SYNC, NRZI
// data with bit stuffing, and EOP on the D+/D- pads. All outputs are
// registered; one USB bit lasts DIV clk cycles.
module usb_line_tx #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       pad_dp,
  output logic       pad_dn,
  output logic       pad_oe,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(DIV - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // clk cycles into the current bit time
  logic [2:0]    bit_q, bit_d;      // bit index within SYNC/byte, or EOP bit index
  logic [2:0]    ones_q, ones_d;    // consecutive data 1s for bit stuffing
  logic [7:0]    shift_q, shift_d;  // current byte, bit 0 is the bit on the line
  logic          last_q, last_d;    // current byte ends the packet
  logic          stuff_q, stuff_d;  // the bit on the line is a stuff bit
  logic          eopnx_q, eopnx_d;  // go to EOP once the current stuff bit ends
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;
  logic          underrun_q, underrun_d;

  logic          bnd;
  logic          send_en;
  logic          send_val;
  logic          goto_eop;

  assign bnd      = (cnt_q == CNT_MAX);
  assign in_ready = in_ready_q;
  assign pad_dp   = dp_q;
  assign pad_dn   = dn_q;
  assign pad_oe   = oe_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

  // Next-state logic: bit timing, SYNC/data serialisation, NRZI, stuffing, EOP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ones_d     = ones_q;
    shift_d    = shift_q;
    last_d     = last_q;
    stuff_d    = stuff_q;
    eopnx_d    = eopnx_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    in_ready_d = 1'b0;
    underrun_d = 1'b0;
    send_en    = 1'b0;
    send_val   = 1'b0;
    goto_eop   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bnd ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = SYNC;
          oe_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          bit_d    = 3'd0;
          stuff_d  = 1'b0;
          eopnx_d  = 1'b0;
          send_en  = 1'b1;   // first SYNC bit is a 0: J -> K
          send_val = 1'b0;
        end
      end

      SYNC: begin
        // Strobe in the last cycle of the final SYNC bit; the byte is taken
        // on the edge that starts the first data bit.
        if (cnt_q == CNT_PRE && bit_q == 3'd7) begin
          in_ready_d = 1'b1;
        end
        if (bnd) begin
          if (bit_q != 3'd7) begin
            bit_d    = bit_q + 3'd1;
            send_en  = 1'b1;
            send_val = (bit_q == 3'd6);
          end else if (in_valid) begin
            state_d  = DATA;
            shift_d  = in_data;
            last_d   = in_last;
            bit_d    = 3'd0;
            send_en  = 1'b1;
            send_val = in_data[0];
          end else begin
            underrun_d = 1'b1;
            goto_eop   = 1'b1;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_PRE && bit_q == 3'd7 && !stuff_q && !last_q) begin
          in_ready_d = 1'b1;
        end
        if (bnd) begin
          // The next byte is fetched at the end of the last data bit even
          // when a stuff bit still has to go out before it.
          if (in_ready_q) begin
            if (in_valid) begin
              shift_d = in_data;
              last_d  = in_last;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (!stuff_q && ones_q == 3'd6) begin
            stuff_d  = 1'b1;
            send_en  = 1'b1;
            send_val = 1'b0;
            eopnx_d  = (bit_q == 3'd7) && (last_q || (in_ready_q && !in_valid));
          end else if (stuff_q && eopnx_q) begin
            goto_eop = 1'b1;
          end else if (bit_q == 3'd7) begin
            stuff_d = 1'b0;
            if (stuff_q) begin
              bit_d    = 3'd0;
              send_en  = 1'b1;
              send_val = shift_q[0];
            end else if (last_q || !in_valid) begin
              goto_eop = 1'b1;
            end else begin
              bit_d    = 3'd0;
              send_en  = 1'b1;
              send_val = in_data[0];
            end
          end else begin
            stuff_d  = 1'b0;
            bit_d    = bit_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            send_en  = 1'b1;
            send_val = shift_q[1];
          end
        end
      end

      EOP: begin
        if (bnd) begin
          if (bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else if (bit_q == 3'd1) begin
            bit_d = 3'd2;
            dp_d  = 1'b1;
            dn_d  = 1'b0;
          end else begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            bit_d   = 3'd0;
            cnt_d   = '0;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // NRZI: a 0 toggles the line and breaks the run of 1s; a 1 holds it.
    if (send_en) begin
      if (send_val) begin
        ones_d = ones_q + 3'd1;
      end else begin
        dp_d   = ~dp_q;
        dn_d   = ~dn_q;
        ones_d = 3'd0;
      end
    end

    if (goto_eop) begin
      state_d = EOP;
      dp_d    = 1'b0;
      dn_d    = 1'b0;
      bit_d   = 3'd0;
      stuff_d = 1'b0;
      eopnx_d = 1'b0;
      ones_d  = 3'd0;
    end
  end

  // State and output registers; reset parks the line at idle J, driver off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      ones_q     <= 3'd0;
      shift_q    <= 8'd0;
      last_q     <= 1'b0;
      stuff_q    <= 1'b0;
      eopnx_q    <= 1'b0;
      dp_q       <= 1'b1;
      dn_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ones_q     <= ones_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      stuff_q    <= stuff_d;
      eopnx_q    <= eopnx_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_usb_line_tx.sv
// Bench for usb_line_tx: a driver sends directed packets and queues the
// hand-derived line pattern for each; a monitor captures every pad_oe window
// and compares it against the queue.
module tb_usb_line_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       pad_dp;
  logic       pad_dn;
  logic       pad_oe;
  logic       busy;
  logic       underrun;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string line;   // one char per bit time: J, K, 0 (SE0)
    int    oe;     // pad_oe high cycles
    int    nr;     // in_ready pulses
    int    nu;     // underrun pulses
    string gaps;   // cycles between successive in_ready pulses
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] pkt [0:7];

  usb_line_tx #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pad_dp   (pad_dp),
    .pad_dn   (pad_dn),
    .pad_oe   (pad_oe),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input string line, input int oe, input int nr,
                            input int nu, input string gaps);
    exp_t e;
    e.line = line; e.oe = oe; e.nr = nr; e.nu = nu; e.gaps = gaps;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  bit    coll = 1'b0;
  int    cyc, nr, nu, lastr;
  string raw, gaps;

  function automatic string sym(input logic dp, input logic dn);
    if (dp && !dn) return "J";
    if (!dp && dn) return "K";
    if (!dp && !dn) return "0";
    return "X";
  endfunction

  task automatic finish_pkt();
    exp_t  e;
    string line = "";
    int    steady = 1;
    if (cyc % DIV != 0) steady = 0;
    for (int i = 0; i < cyc / DIV; i++) begin
      for (int j = 1; j < DIV; j++) begin
        if (raw.substr(i*DIV + j, i*DIV + j) != raw.substr(i*DIV, i*DIV)) steady = 0;
      end
      line = {line, raw.substr(i*DIV, i*DIV)};
    end
    if (exp_q.size() == 0) begin
      chk_int("unexpected_packet", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk_str("line", line, e.line);
      chk_int("oe_cycles", cyc, e.oe);
      chk_int("in_ready_pulses", nr, e.nr);
      chk_int("underrun_pulses", nu, e.nu);
      chk_str("ready_gaps", gaps, e.gaps);
      chk_int("bit_steady", steady, 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      coll = 1'b0;
    end else if (pad_oe) begin
      if (!coll) begin
        coll = 1'b1; cyc = 0; raw = ""; nr = 0; nu = 0; gaps = ""; lastr = -1;
      end
      raw = {raw, sym(pad_dp, pad_dn)};
      cyc++;
      if (in_ready) begin
        if (lastr >= 0) gaps = {gaps, (gaps.len() > 0) ? "," : "", $sformatf("%0d", cyc - lastr)};
        lastr = cyc;
        nr++;
      end
      if (underrun) nu++;
    end else if (coll) begin
      coll = 1'b0;
      finish_pkt();
    end
  end

  // ---------------- driver ----------------
  task automatic send_pkt(input int n, input int n_give);
    int given = 0;
    int guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = pkt[0]; in_last = (n == 1);
    if (n_give == 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    while (given < n_give && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        @(posedge clk); #1;
        given++;
        if (given < n_give) begin
          in_data = pkt[given]; in_last = (given == n - 1);
        end else begin
          in_valid = 1'b0; in_last = 1'b0;
        end
      end
    end
    if (guard >= 2000) chk_int("handshake_timeout", guard, 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy || pad_oe) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk_int("idle_timeout", guard, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    in_data = 8'h00; in_last = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_int("reset_outputs", int'({pad_oe, pad_dp, pad_dn, busy, in_ready, underrun}), int'(6'b010000));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_int("idle_outputs", int'({pad_oe, pad_dp, pad_dn, busy, in_ready, underrun}), int'(6'b010000));

    // 0xD2 single byte
    pkt[0] = 8'hD2;
    expect_pkt("KJKJKJKKJJKJJKKK00J", 76, 1, 0, "");
    send_pkt(1, 1); wait_idle();

    // 0xFC: stuff bit right before EOP
    pkt[0] = 8'hFC;
    expect_pkt("KJKJKJKKJKKKKKKKJ00J", 80, 1, 0, "");
    send_pkt(1, 1); wait_idle();

    // 0xFF 0xFF: two stuff bits
    pkt[0] = 8'hFF; pkt[1] = 8'hFF;
    expect_pkt("KJKJKJKKKKKKKJJJJJJJKKKKKK00J", 116, 2, 0, "36");
    send_pkt(2, 2); wait_idle();

    // starvation at the second byte
    pkt[0] = 8'h00; pkt[1] = 8'h55;
    expect_pkt("KJKJKJKKJKJKJKJK00J", 76, 2, 1, "32");
    send_pkt(2, 1); wait_idle();

    // starvation at the first data slot
    pkt[0] = 8'hA5;
    expect_pkt("KJKJKJKK00J", 44, 1, 1, "");
    send_pkt(1, 0); wait_idle();

    // four 0x00 bytes back to back
    for (int i = 0; i < 4; i++) pkt[i] = 8'h00;
    expect_pkt("KJKJKJKKJKJKJKJKJKJKJKJKJKJKJKJKJKJKJKJK00J", 172, 4, 0, "32,32,32");
    send_pkt(4, 4); wait_idle();

    // reset in the middle of DATA
    pkt[0] = 8'hD2;
    send_pkt(1, 1);
    repeat (10) @(negedge clk);
    chk_int("busy_in_data", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_int("reset_mid_packet", int'({pad_oe, pad_dp, pad_dn, busy, in_ready, underrun}), int'(6'b010000));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_pkt("KJKJKJKKJJKJJKKK00J", 76, 1, 0, "");
    send_pkt(1, 1); wait_idle();

    repeat (5) @(negedge clk);
    chk_int("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
